dsa_simd_sched_fsm: RTL and testbench

//  Next-generation SIMD control FSM for the bilinear-interpolation DSA.

---
 rtl/dsa_simd_pkg.sv | 44 ++++
 rtl/dsa_simd_sched_fsm_if.sv | 26 ++
 rtl/dsa_wait_timer.sv | 30 +++
 rtl/dsa_simd_sched_fsm.sv | 170 +++++++++++++++++
 tb/tb_dsa_simd_sched_fsm.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dsa_simd_pkg.sv
// dsa_simd_pkg: shared types and helpers for the SIMD group scheduler.
// Lane counts are 5 bits wide so a full 16-lane group is representable.
package dsa_simd_pkg;

  localparam int unsigned SIMD_MAX = 16;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    REQ      = 4'd2,
    WAIT_F   = 4'd3,
    START_DP = 4'd4,
    WAIT_DP  = 4'd5,
    WRITE    = 4'd6,
    NEXT     = 4'd7,
    PAUSE    = 4'd8,
    DONE     = 4'd9,
    ERR      = 4'd10
  } state_t;

  // Lanes left in the row, capped at the group width.
  function automatic logic [4:0] active_lanes(
    input logic [15:0] x,
    input logic [15:0] w,
    input int unsigned simd
  );
    logic [16:0] rem;
    rem = {1'b0, w} - {1'b0, x};
    if (rem > 17'(simd)) return 5'(simd);
    return rem[4:0];
  endfunction

  function automatic logic [SIMD_MAX-1:0] lane_mask_of(
    input logic [4:0] n
  );
    logic [SIMD_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < SIMD_MAX; i++) begin
      m[i] = (5'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/dsa_simd_sched_fsm_if.sv
// dsa_simd_sched_fsm_if: fetch/datapath handshakes and lane write strobes.
// master = scheduler, slave = fetch unit and SIMD datapath.
interface dsa_simd_sched_fsm_if #(
  parameter int unsigned SIMD_WIDTH = 4,
  parameter int unsigned IDX_W      = 2
);
  logic                  fetch_req;
  logic                  fetch_done;
  logic                  dp_start;
  logic                  dp_done;
  logic [SIMD_WIDTH-1:0] lane_mask;
  logic                  write_enable;
  logic [IDX_W-1:0]      write_index;

  modport master (
    output fetch_req, dp_start, lane_mask,
    output write_enable, write_index,
    input  fetch_done, dp_done
  );

  modport slave (
    input  fetch_req, dp_start, lane_mask,
    input  write_enable, write_index,
    output fetch_done, dp_done
  );
endinterface

// File: rtl/dsa_wait_timer.sv
// dsa_wait_timer: watchdog for the fetch/datapath wait states.
// expired is high in the last allowed cycle of a wait; 0 disables it.
module dsa_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        cnt_q <= '0;
      end else if (run && cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = run && (cnt_q == LAST);
  end
endmodule

// File: rtl/dsa_simd_sched_fsm.sv
// dsa_simd_sched_fsm: SIMD group scheduler for the bilinear DSA.
// Walks the output raster in lane groups: fetch, datapath, per-lane write.
module dsa_simd_sched_fsm
  import dsa_simd_pkg::*;
#(
  parameter int unsigned SIMD_WIDTH     = 4,
  parameter int unsigned IDX_W          =
    (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IMG_WIDTH_MAX  = 512,
  parameter int unsigned IMG_HEIGHT_MAX = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        abort,
  input  logic        step_mode,
  input  logic        step,
  input  logic [15:0] img_width_out,
  input  logic [15:0] img_height_out,
  dsa_simd_sched_fsm_if.master bus,
  output logic [15:0] current_x,
  output logic [15:0] current_y,
  output logic [31:0] pixels_done,
  output logic        busy,
  output logic        ready,
  output logic        error
);
  state_t state_q, state_d;
  logic [15:0] w_q, w_d, h_q, h_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] pix_q, pix_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SIMD_WIDTH-1:0] mask_q, mask_d;
  logic [SIMD_MAX-1:0] full_mask;
  logic freq_q, dps_q, we_q;
  logic busy_q, rdy_q, err_q;
  logic [4:0] n_cur;
  logic [16:0] x_end;
  logic last_lane, expired;

  assign n_cur     = active_lanes(x_q, w_q, SIMD_WIDTH);
  assign x_end     = {1'b0, x_q} + 17'(n_cur);
  assign last_lane = (5'(idx_q) == n_cur - 5'd1);

  dsa_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == REQ || state_q == START_DP),
    .run    (state_q == WAIT_F || state_q == WAIT_DP),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    pix_d     = pix_q;
    idx_d     = '0;
    mask_d    = '0;
    full_mask = '0;
    unique case (state_q)
      IDLE: if (enable) state_d = INIT;
      INIT: begin
        w_d = (img_width_out > 16'(IMG_WIDTH_MAX)) ?
              16'(IMG_WIDTH_MAX) : img_width_out;
        h_d = (img_height_out > 16'(IMG_HEIGHT_MAX)) ?
              16'(IMG_HEIGHT_MAX) : img_height_out;
        x_d   = '0;
        y_d   = '0;
        pix_d = '0;
        state_d = (w_d == '0 || h_d == '0) ? DONE : REQ;
      end
      REQ: state_d = WAIT_F;
      // A done arriving with the timeout still wins.
      WAIT_F: begin
        if (bus.fetch_done) state_d = START_DP;
        else if (expired)   state_d = ERR;
      end
      START_DP: state_d = WAIT_DP;
      WAIT_DP: begin
        if (bus.dp_done)  state_d = WRITE;
        else if (expired) state_d = ERR;
      end
      WRITE: if (last_lane) state_d = NEXT;
      NEXT: begin
        pix_d = pix_q + 32'(n_cur);
        if (x_end < {1'b0, w_q}) begin
          x_d = x_q + 16'(n_cur);
        end else begin
          x_d = '0;
          y_d = y_q + 16'd1;
        end
        if (x_end >= {1'b0, w_q} &&
            {1'b0, y_q} + 17'd1 >= {1'b0, h_q})
          state_d = DONE;
        else if (step_mode)
          state_d = PAUSE;
        else
          state_d = REQ;
      end
      PAUSE: if (step || !step_mode) state_d = REQ;
      DONE:  if (!enable) state_d = IDLE;
      ERR:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) state_d = IDLE;

    if (state_q == WRITE && state_d == WRITE)
      idx_d = idx_q + 1'b1;

    if (state_d inside {REQ, WAIT_F, START_DP, WAIT_DP, WRITE}) begin
      full_mask = lane_mask_of(active_lanes(x_d, w_d, SIMD_WIDTH));
      mask_d    = full_mask[SIMD_WIDTH-1:0];
    end else if (state_d == NEXT) begin
      mask_d = mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      freq_q  <= 1'b0;
      dps_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      freq_q  <= (state_d == REQ);
      dps_q   <= (state_d == START_DP);
      we_q    <= (state_d == WRITE);
      busy_q  <= !(state_d inside {IDLE, DONE, ERR});
      rdy_q   <= (state_d == DONE);
      err_q   <= (state_d == ERR);
    end
  end

  assign bus.fetch_req    = freq_q;
  assign bus.dp_start     = dps_q;
  assign bus.write_enable = we_q;
  assign bus.write_index  = idx_q;
  assign bus.lane_mask    = mask_q;
  assign current_x        = x_q;
  assign current_y        = y_q;
  assign pixels_done      = pix_q;
  assign busy             = busy_q;
  assign ready            = rdy_q;
  assign error            = err_q;
endmodule

// File: tb/tb_dsa_simd_sched_fsm.sv
// tb_dsa_simd_sched_fsm: directed + randomized bench for the SIMD scheduler.
// Expected groups come from a raster walk model built per image.
module tb_dsa_simd_sched_fsm;
  localparam int SW = 4;
  localparam int IW = 2;

  logic        clk = 1'b0;
  logic        rst, enable, abort, step_mode, step;
  logic [15:0] img_width_out, img_height_out;
  logic [15:0] current_x, current_y;
  logic [31:0] pixels_done;
  logic        busy, ready, error;
  int          total = 0;
  int          bad = 0;

  typedef struct { int x; int y; int n; } grp_t;

  dsa_simd_sched_fsm_if #(.SIMD_WIDTH(SW), .IDX_W(IW)) bus ();

  dsa_simd_sched_fsm #(
    .SIMD_WIDTH(SW),
    .IDX_W(IW),
    .TIMEOUT_CYCLES(16),
    .IMG_WIDTH_MAX(512),
    .IMG_HEIGHT_MAX(512)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .abort         (abort),
    .step_mode     (step_mode),
    .step          (step),
    .img_width_out (img_width_out),
    .img_height_out(img_height_out),
    .bus           (bus),
    .current_x     (current_x),
    .current_y     (current_y),
    .pixels_done   (pixels_done),
    .busy          (busy),
    .ready         (ready),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_req(output int k);
    k = 0;
    while (bus.fetch_req !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Runs one image; ab_g/ab_l >= 0 aborts at that group/lane.
  task automatic run_img(input int w, input int h, input int lf,
                         input int ld, input bit sm,
                         input int ab_g, input int ab_l);
    grp_t q[$];
    grp_t g;
    int ew, eh, pix, k, nw, nfr;
    ew = (w > 512) ? 512 : w;
    eh = (h > 512) ? 512 : h;
    for (int y = 0; y < eh; y++)
      for (int x = 0; x < ew; x += SW) begin
        g.x = x;
        g.y = y;
        g.n = (ew - x < SW) ? ew - x : SW;
        q.push_back(g);
      end
    img_width_out  = 16'(w);
    img_height_out = 16'(h);
    step_mode = sm;
    enable = 1'b1;
    pix = 0;
    for (int i = 0; i < q.size(); i++) begin
      g = q[i];
      wait_req(k);
      if (i == 0) chk("req_lat", k, 2);
      chk("req_seen", 32'(bus.fetch_req), 1);
      if (k >= 40) return;
      chk("req_x", 32'(current_x), g.x);
      chk("req_y", 32'(current_y), g.y);
      chk("mask", 32'(bus.lane_mask), (32'd1 << g.n) - 1);
      chk("pix_mid", pixels_done, pix);
      img_width_out  = 16'($urandom);
      img_height_out = 16'($urandom);
      for (int c = 0; c < lf; c++) begin
        @(negedge clk);
        bus.dp_done = 1'($urandom_range(0, 1));
      end
      bus.dp_done = 1'b0;
      bus.fetch_done = 1'b1;
      @(negedge clk);
      bus.fetch_done = 1'b0;
      chk("dp_start", 32'(bus.dp_start), 1);
      for (int c = 0; c < ld; c++) begin
        @(negedge clk);
        bus.fetch_done = 1'($urandom_range(0, 1));
      end
      bus.fetch_done = 1'b0;
      bus.dp_done = 1'b1;
      @(negedge clk);
      bus.dp_done = 1'b0;
      nw = 0;
      while (bus.write_enable === 1'b1 && nw < 20) begin
        chk("widx", 32'(bus.write_index), nw);
        if (i == ab_g && nw == ab_l) begin
          abort = 1'b1;
          enable = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          chk("ab_we", 32'(bus.write_enable), 0);
          chk("ab_busy", 32'(busy), 0);
          chk("ab_mask", 32'(bus.lane_mask), 0);
          @(negedge clk);
          chk("ab_req", 32'(bus.fetch_req), 0);
          return;
        end
        nw++;
        @(negedge clk);
      end
      chk("nwrites", nw, g.n);
      pix += g.n;
      if (sm && i + 1 < q.size()) begin
        k = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus.fetch_req) k++;
        end
        chk("pause_req", k, 0);
        chk("pause_x", 32'(current_x), q[i+1].x);
        chk("pause_y", 32'(current_y), q[i+1].y);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
      end
    end
    k = 0;
    nfr = 0;
    while (ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      if (bus.fetch_req) nfr++;
      k++;
    end
    if (q.size() == 0) chk("done_lat", k, 2);
    chk("tail_req", nfr, 0);
    chk("ready", 32'(ready), 1);
    chk("pix_end", pixels_done, ew * eh);
    chk("end_busy", 32'(busy), 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle", 32'(ready), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    enable = 1'b0;
    abort = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    img_width_out = '0;
    img_height_out = '0;
    bus.fetch_done = 1'b0;
    bus.dp_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.fetch_req), 0);
    chk("rst_we", 32'(bus.write_enable), 0);
    chk("rst_mask", 32'(bus.lane_mask), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(ready), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_pix", pixels_done, 0);
    chk("rst_xy", 32'({current_x, current_y}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_img(8, 2, 3, 3, 1'b0, -1, -1);
    run_img(10, 1, 3, 3, 1'b0, -1, -1);
    run_img(0, 5, 1, 1, 1'b0, -1, -1);

    img_width_out = 16'd8;
    img_height_out = 16'd1;
    enable = 1'b1;
    wait_req(k);
    chk("to_req", k, 2);
    repeat (16) @(negedge clk);
    chk("to_early", 32'(error), 0);
    @(negedge clk);
    chk("to_err", 32'(error), 1);
    chk("to_busy", 32'(busy), 0);
    enable = 1'b0;
    @(negedge clk);
    chk("to_idle", 32'(error), 0);

    run_img(8, 1, 2, 2, 1'b1, -1, -1);
    run_img(8, 1, 2, 2, 1'b0, 1, 1);
    run_img(8, 1, 1, 2, 1'b0, -1, -1);

    for (int r = 0; r < 6; r++)
      run_img($urandom_range(1, 23), $urandom_range(1, 3),
              $urandom_range(1, 6), $urandom_range(1, 6),
              1'($urandom_range(0, 1)), -1, -1);

    run_img(600, 1, 1, 1, 1'b0, -1, -1);
    run_img(1, 700, 1, 1, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
